// File: rtl/mem_pkg.sv
// mem_pkg: shared size/state encodings and the access fault rule for the data memory.
package mem_pkg;
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_WAIT, ST_RESP} state_t;
   function automatic logic access_err(input logic [1:0] size, input logic [1:0] lo, input logic oor);
      return size == 2'b11 || (size == SZ_HALF && lo[0]) || (size == SZ_WORD && lo != 2'b00) || oor;
   endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: little-endian byte-lane steering for stores and lane extraction/extension for loads.
module mem_lane_align
   import mem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        uns,
   input  logic [1:0]  lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wdata_sh,
   output logic [31:0] rdata_ext
);
   logic [7:0]  rb;
   logic [15:0] rh;
   always_comb begin
      rb = rword[{lo, 3'b000} +: 8];
      rh = rword[{lo[1], 4'b0000} +: 16];
      be = size == SZ_BYTE ? 4'b0001 << lo : size == SZ_HALF ? 4'b0011 << {lo[1], 1'b0} : 4'b1111;
      // replicating the data puts it on every candidate lane; the enables pick the right one
      wdata_sh = size == SZ_BYTE ? {4{wdata[7:0]}} : size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
      rdata_ext = size == SZ_BYTE ? {{24{rb[7] & ~uns}}, rb}
                : size == SZ_HALF ? {{16{rh[15] & ~uns}}, rh} : rword;
   end
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: word-organised data memory with valid/ready requests, fixed response latency,
// byte/half/word accesses with extension, fault reporting and a one-word-per-cycle clear after reset.
module data_mem_ctrl
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 64,
   parameter int LATENCY    = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [31:0]           req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  busy
);
   localparam int IW = $clog2(DEPTH);
   localparam logic [2:0] LAT_M1 = 3'(LATENCY == 0 ? 0 : LATENCY - 1);
   localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

   state_t state_q, state_d;
   logic [IW-1:0] clear_idx_q, clear_idx_d, idx, wr_idx;
   logic [2:0] cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d, cur_addr, cur_wdata;
   logic [1:0] size_q, size_d, cur_size;
   logic we_q, we_d, uns_q, uns_d, cur_we, cur_uns;
   logic req_ready_q, req_ready_d, busy_q, busy_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic idle, accept, err, enter_resp, wr_en;
   logic [3:0] be;
   logic [31:0] wmask, wdata_sh, rdata_ext, wr_word;
   logic [31:0] mem_q [DEPTH];

   mem_lane_align u_align (
      .size(cur_size), .uns(cur_uns), .lo(cur_addr[1:0]), .wdata(cur_wdata),
      .rword(mem_q[idx]), .be(be), .wdata_sh(wdata_sh), .rdata_ext(rdata_ext)
   );

   // with LATENCY=0 the access completes on the accept edge, so the live request is used directly
   always_comb begin
      idle = state_q == ST_IDLE;
      cur_addr = idle ? req_addr : addr_q;
      cur_wdata = idle ? req_wdata : wdata_q;
      cur_size = idle ? req_size : size_q;
      cur_we = idle ? req_we : we_q;
      cur_uns = idle ? req_unsigned : uns_q;
      accept = req_ready_q && req_valid;
      idx = cur_addr[IW+1:2];
      err = access_err(cur_size, cur_addr[1:0], |cur_addr[31:IW+2]);
      enter_resp = (accept && LATENCY == 0) || (state_q == ST_WAIT && cnt_q == 3'd0);
      state_d = state_q == ST_CLEAR ? (clear_idx_q == LAST ? ST_IDLE : ST_CLEAR)
              : state_q == ST_RESP ? ST_IDLE
              : enter_resp ? ST_RESP
              : accept ? ST_WAIT : state_q;
      clear_idx_d = state_q == ST_CLEAR ? clear_idx_q + 1'b1 : clear_idx_q;
      cnt_d = accept ? LAT_M1 : state_q == ST_WAIT ? cnt_q - 3'd1 : cnt_q;
      addr_d = accept ? req_addr : addr_q;
      wdata_d = accept ? req_wdata : wdata_q;
      size_d = accept ? req_size : size_q;
      we_d = accept ? req_we : we_q;
      uns_d = accept ? req_unsigned : uns_q;
      req_ready_d = state_d == ST_IDLE;
      busy_d = state_d != ST_IDLE;
      rsp_valid_d = enter_resp;
      rsp_err_d = enter_resp && err;
      rsp_rdata_d = (enter_resp && !err && !cur_we) ? rdata_ext : 32'd0;
      wmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      wr_en = state_q == ST_CLEAR || (enter_resp && !err && cur_we);
      wr_idx = state_q == ST_CLEAR ? clear_idx_q : idx;
      wr_word = state_q == ST_CLEAR ? 32'd0 : (mem_q[idx] & ~wmask) | (wdata_sh & wmask);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_CLEAR;
         clear_idx_q <= '0;
         cnt_q <= 3'd0;
         req_ready_q <= 1'b0;
         busy_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q <= 1'b0;
         rsp_rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         clear_idx_q <= clear_idx_d;
         cnt_q <= cnt_d;
         req_ready_q <= req_ready_d;
         busy_q <= busy_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   // a reset arriving mid-access must abort the pending write
   always_ff @(posedge clk) begin
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      size_q <= size_d;
      we_q <= we_d;
      uns_q <= uns_d;
      if (wr_en && !reset) mem_q[wr_idx] <= wr_word;
   end

   assign req_ready = req_ready_q;
   assign busy = busy_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed plus randomized checks of data_mem_ctrl against a byte-array model,
// one instance at LATENCY=2 and one at LATENCY=0 for back-to-back streaming.
module tb_data_mem_ctrl;
   localparam int DEPTH = 64;
   localparam int LAT = 2;

   logic clk = 0, reset = 1;
   logic req_valid = 0, req_we = 0, req_unsigned = 0;
   logic [1:0] req_size = 0;
   logic [31:0] req_addr = 0, req_wdata = 0;
   logic req_ready, rsp_valid, rsp_err, busy;
   logic [31:0] rsp_rdata;
   logic z_valid = 0, z_we = 0, z_uns = 0;
   logic [1:0] z_size = 0;
   logic [31:0] z_addr = 0, z_wdata = 0;
   logic z_ready, z_rsp_valid, z_rsp_err, z_busy;
   logic [31:0] z_rdata;

   int checks = 0, errors = 0;
   logic [7:0] ref_mem [2][DEPTH*4];
   logic [31:0] exp_d_q[$];
   logic exp_e_q[$];

   always #5 clk = ~clk;

   data_mem_ctrl #(.DATA_WIDTH(32), .DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy));

   data_mem_ctrl #(.DATA_WIDTH(32), .DEPTH(DEPTH), .LATENCY(0)) u_dut0 (
      .clk(clk), .reset(reset), .req_valid(z_valid), .req_ready(z_ready), .req_we(z_we),
      .req_size(z_size), .req_unsigned(z_uns), .req_addr(z_addr), .req_wdata(z_wdata),
      .rsp_valid(z_rsp_valid), .rsp_rdata(z_rdata), .rsp_err(z_rsp_err), .busy(z_busy));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      for (int m = 0; m < 2; m++) for (int i = 0; i < DEPTH*4; i++) ref_mem[m][i] = 8'h00;
   endtask

   // byte-addressed little-endian model; a fault leaves memory alone and returns zero
   task automatic model(input int m, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err);
      int n;
      n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
      err = sz == 2'd3 || (a % n) != 0 || (a >> 2) >= DEPTH;
      rd = 32'd0;
      if (err) return;
      for (int i = 0; i < n; i++)
         if (we) ref_mem[m][a+i] = 8'(wd >> (8*i));
         else rd = rd | (32'(ref_mem[m][a+i]) << (8*i));
      if (!we && !uns && n < 4 && rd[8*n-1]) rd = rd | ~((32'd1 << (8*n)) - 32'd1);
   endtask

   task automatic wait_ready(input string tag, input int exp_n);
      int n;
      n = 0;
      while (req_ready !== 1'b1 && n < 500) begin @(negedge clk); n++; end
      if (exp_n >= 0) chk(tag, n, exp_n);
      else chk(tag, 32'(n < 500), 32'd1);
   endtask

   task automatic access(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
      logic [31:0] ed;
      logic ee;
      int n;
      wait_ready({tag, " ready"}, -1);
      model(0, we, sz, uns, a, wd, ed, ee);
      req_valid = 1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
      @(negedge clk);
      n = 1;
      while (rsp_valid !== 1'b1 && n < 50) begin
         req_we = 1'($urandom); req_size = 2'($urandom); req_addr = $urandom; req_wdata = $urandom;
         @(negedge clk);
         n++;
      end
      req_valid = 0;
      chk({tag, " latency"}, n, LAT + 1);
      chk({tag, " rdata"}, rsp_rdata, ed);
      chk({tag, " err"}, 32'(rsp_err), 32'(ee));
      @(negedge clk);
      chk({tag, " pulse"}, 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      logic [31:0] ed, a;
      logic ee, prev, seen;
      logic [1:0] sz;
      int acc, rsp;
      repeat (3) @(negedge clk);
      chk("rst ready", 32'(req_ready), 32'd0);
      chk("rst busy", 32'(busy), 32'd1);
      chk("rst valid", 32'(rsp_valid), 32'd0);
      chk("rst rdata", rsp_rdata, 32'd0);
      chk("rst err", 32'(rsp_err), 32'd0);
      clear_model();
      reset = 0;
      @(negedge clk);
      chk("clear busy", 32'(busy), 32'd1);
      wait_ready("clear len", DEPTH - 1);
      chk("idle busy", 32'(busy), 32'd0);
      access("t1 load0", 0, 2'd2, 0, 32'h0, 32'h0);
      access("t2 st", 1, 2'd2, 0, 32'h8, 32'h12345678);
      access("t2 lw", 0, 2'd2, 0, 32'h8, 32'h0);
      access("t2 lb", 0, 2'd0, 0, 32'hB, 32'h0);
      access("t2 lh", 0, 2'd1, 0, 32'hA, 32'h0);
      access("t3 sb", 1, 2'd0, 0, 32'h5, 32'hFFFFFF80);
      access("t3 lw", 0, 2'd2, 0, 32'h4, 32'h0);
      access("t3 lbs", 0, 2'd0, 0, 32'h5, 32'h0);
      access("t3 lbu", 0, 2'd0, 1, 32'h5, 32'h0);
      access("t4 seed", 1, 2'd2, 0, 32'h0, 32'hA5C3_9E71);
      access("t4 sh3", 1, 2'd1, 0, 32'h3, $urandom);
      access("t4 lh3", 0, 2'd1, 1, 32'h3, 32'h0);
      access("t4 sw2", 1, 2'd2, 0, 32'h2, $urandom);
      access("t4 sz3", 1, 2'd3, 0, 32'h8, $urandom);
      access("t4 oor", 1, 2'd2, 0, 32'h100, $urandom);
      access("t4 chk0", 0, 2'd2, 0, 32'h0, 32'h0);
      access("t4 chk8", 0, 2'd2, 0, 32'h8, 32'h0);
      // reset lands while the store to 0x10 is waiting
      wait_ready("t5 ready", -1);
      req_valid = 1; req_we = 1; req_size = 2'd2; req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
      @(negedge clk);
      req_valid = 0;
      reset = 1;
      seen = 0;
      repeat (4) begin @(negedge clk); seen = seen | rsp_valid; end
      chk("t5 no rsp", 32'(seen), 32'd0);
      chk("t5 busy", 32'(busy), 32'd1);
      reset = 0;
      clear_model();
      @(negedge clk);
      wait_ready("t5 clear len", DEPTH - 1);
      access("t5 ld10", 0, 2'd2, 0, 32'h10, 32'h0);
      for (int i = 0; i < 40; i++) begin
         sz = $urandom_range(0, 9) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
         a = $urandom_range(0, DEPTH*4 + 7);
         if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 1);
         access("rand", 1'($urandom), sz, 1'($urandom), a, $urandom);
      end
      // LATENCY=0 instance with request held valid the whole time
      chk("z ready", 32'(z_ready), 32'd1);
      prev = 0; acc = 0; rsp = 0;
      z_valid = 1;
      for (int c = 0; c < 41; c++) begin
         chk("z valid", 32'(z_rsp_valid), 32'(prev));
         chk("z alt", 32'(z_ready), 32'(!prev));
         if (z_rsp_valid) begin
            rsp++;
            chk("z pending", exp_d_q.size(), 32'd1);
            if (exp_d_q.size() != 0) begin
               chk("z rdata", z_rdata, exp_d_q.pop_front());
               chk("z err", 32'(z_rsp_err), 32'(exp_e_q.pop_front()));
            end
         end
         if (c == 40) z_valid = 0;
         sz = $urandom_range(0, 9) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
         a = $urandom_range(0, 63) & ~((32'd1 << sz) - 1);
         z_we = 1'($urandom); z_size = sz; z_uns = 1'($urandom); z_addr = a; z_wdata = $urandom;
         prev = z_ready && z_valid;
         if (prev) begin
            acc++;
            model(1, z_we, z_size, z_uns, z_addr, z_wdata, ed, ee);
            exp_d_q.push_back(ed);
            exp_e_q.push_back(ee);
         end
         @(negedge clk);
      end
      chk("z count", rsp, acc);
      chk("z drained", exp_d_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
